// File: rtl/sbox_checker_if.sv
// sbox_checker_if: share buses, controls and statistics between the testbench and the S-box checker.
interface sbox_checker_if #(
    parameter int d     = 2,
    parameter int LANES = 4,
    parameter int CW    = 16
);
    logic                   enable;
    logic                   clear;
    logic                   in_valid;
    logic [8*d*LANES-1:0]   sh_to_sb;
    logic [8*d*LANES-1:0]   sh_from_sb;
    logic                   busy;
    logic                   err;
    logic [CW-1:0]          n_checks;
    logic [CW-1:0]          n_errors;
    logic [3:0]             first_lane;
    logic [7:0]             first_in;
    logic [7:0]             first_exp;
    logic [7:0]             first_got;
    modport master (
        output enable, clear, in_valid, sh_to_sb, sh_from_sb,
        input  busy, err, n_checks, n_errors, first_lane, first_in, first_exp, first_got
    );
    modport slave (
        input  enable, clear, in_valid, sh_to_sb, sh_from_sb,
        output busy, err, n_checks, n_errors, first_lane, first_in, first_exp, first_got
    );
endinterface

// File: rtl/sbox_checker.sv
// sbox_checker: recombines masked S-box lane shares, aligns inputs to outputs across the S-box
// latency and checks each lane against the AES S-box, keeping saturating stats and the first mismatch.
module sbox_checker #(
    parameter int d     = 2,
    parameter int LANES = 4,
    parameter int LAT   = 6,
    parameter int CW    = 16
) (
    input logic          clk,
    input logic          rst_n,
    sbox_checker_if.slave sb
);
    localparam int SW = CW + 5;
    localparam logic [SW-1:0] MAX = SW'({CW{1'b1}});
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    typedef enum logic {CLEAN, FAULT} state_t;
    state_t                       r_state, w_state_nxt;
    logic [LAT-1:0]               r_vld;
    logic [LAT-1:0][8*LANES-1:0]  r_pin;
    logic [CW-1:0]                r_n_checks, r_n_errors;
    logic [3:0]                   r_first_lane;
    logic [7:0]                   r_first_in, r_first_exp, r_first_got;
    logic [8*LANES-1:0]           w_in, w_got, w_exp, w_tail;
    logic [LANES-1:0]             w_mis;
    logic [4:0]                   w_pop;
    logic [3:0]                   w_lane;
    logic [7:0]                   w_cin, w_cexp, w_cgot;
    logic                         w_acc, w_chk, w_cap;
    logic [SW-1:0]                w_chk_sum, w_err_sum;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[8*(255-int'(x)) +: 8];
    endfunction

    always_comb begin
        w_tail = r_pin[LAT-1];
        w_in   = '0;
        w_got  = '0;
        w_exp  = '0;
        w_mis  = '0;
        w_pop  = '0;
        w_lane = '0;
        w_cin  = '0;
        w_cexp = '0;
        w_cgot = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int b = 0; b < 8; b++) begin
                w_in[8*i+b]  = ^sb.sh_to_sb[8*d*i+d*b +: d];
                w_got[8*i+b] = ^sb.sh_from_sb[8*d*i+d*b +: d];
            end
            w_exp[8*i +: 8] = sbox(w_tail[8*i +: 8]);
            w_mis[i]        = w_got[8*i +: 8] != w_exp[8*i +: 8];
            w_pop           = w_pop + 5'(w_mis[i]);
        end
        // walk downwards so the lowest mismatching lane is the one left selected
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_mis[i]) begin
                w_lane = 4'(i);
                w_cin  = w_tail[8*i +: 8];
                w_cexp = w_exp[8*i +: 8];
                w_cgot = w_got[8*i +: 8];
            end
        end
    end

    assign w_acc     = sb.in_valid & sb.enable & ~sb.clear;
    assign w_chk     = r_vld[LAT-1] & ~sb.clear;
    assign w_chk_sum = SW'(r_n_checks) + SW'(LANES);
    assign w_err_sum = SW'(r_n_errors) + SW'(w_pop);

    always_comb begin
        w_cap       = w_chk & (|w_mis) & (r_state == CLEAN);
        w_state_nxt = sb.clear ? CLEAN : (w_cap ? FAULT : r_state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CLEAN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || sb.clear) begin
            r_vld        <= '0;
            r_n_checks   <= '0;
            r_n_errors   <= '0;
            r_first_lane <= '0;
            r_first_in   <= '0;
            r_first_exp  <= '0;
            r_first_got  <= '0;
        end else begin
            r_vld[0] <= w_acc;
            for (int k = 1; k < LAT; k++) r_vld[k] <= r_vld[k-1];
            if (w_chk) begin
                r_n_checks <= (w_chk_sum > MAX) ? MAX[CW-1:0] : w_chk_sum[CW-1:0];
                r_n_errors <= (w_err_sum > MAX) ? MAX[CW-1:0] : w_err_sum[CW-1:0];
            end
            if (w_cap) begin
                r_first_lane <= w_lane;
                r_first_in   <= w_cin;
                r_first_exp  <= w_cexp;
                r_first_got  <= w_cgot;
            end
        end
    end

    // payload needs no reset: it is only looked at under its valid bit
    always_ff @(posedge clk) begin
        r_pin[0] <= w_in;
        for (int k = 1; k < LAT; k++) r_pin[k] <= r_pin[k-1];
    end

    assign sb.busy       = |r_vld;
    assign sb.err        = r_state == FAULT;
    assign sb.n_checks   = r_n_checks;
    assign sb.n_errors   = r_n_errors;
    assign sb.first_lane = r_first_lane;
    assign sb.first_in   = r_first_in;
    assign sb.first_exp  = r_first_exp;
    assign sb.first_got  = r_first_got;
endmodule

// File: tb/tb_sbox_checker.sv
// tb_sbox_checker: directed vectors for the S-box checker, main instance plus a 4-bit-counter instance.
module tb_sbox_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    localparam logic [31:0] IN  = 32'hff01_5300;
    localparam logic [31:0] OUT = 32'h167c_ed63;

    always #5 clk = ~clk;

    sbox_checker_if #(.d(2), .LANES(4), .CW(16)) ifa ();
    sbox_checker_if #(.d(2), .LANES(4), .CW(4))  ifb ();

    sbox_checker #(.d(2), .LANES(4), .LAT(6), .CW(16)) u_dut (.clk(clk), .rst_n(rst_n), .sb(ifa));
    sbox_checker #(.d(2), .LANES(4), .LAT(6), .CW(4))  u_sat (.clk(clk), .rst_n(rst_n), .sb(ifb));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input logic [31:0] v);
        logic [63:0] r;
        logic        m;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < 8; b++) begin
                m              = 1'($urandom);
                r[16*i+2*b]    = m;
                r[16*i+2*b+1]  = v[8*i+b] ^ m;
            end
        end
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [31:0] v);
        ifa.in_valid = 1'b1;
        ifa.sh_to_sb = mask(v);
        step(1);
        ifa.in_valid = 1'b0;
    endtask

    task automatic do_clear();
        ifa.clear = 1'b1;
        step(1);
        ifa.clear = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_busy"},  ifa.busy, 0);
        chk({tag, "_err"},   ifa.err, 0);
        chk({tag, "_nchk"},  ifa.n_checks, 0);
        chk({tag, "_nerr"},  ifa.n_errors, 0);
        chk({tag, "_flane"}, ifa.first_lane, 0);
        chk({tag, "_fin"},   ifa.first_in, 0);
        chk({tag, "_fexp"},  ifa.first_exp, 0);
        chk({tag, "_fgot"},  ifa.first_got, 0);
    endtask

    initial begin
        ifa.enable = 1'b1; ifa.clear = 1'b0; ifa.in_valid = 1'b0; ifa.sh_to_sb = '0; ifa.sh_from_sb = '0;
        ifb.enable = 1'b1; ifb.clear = 1'b0; ifb.in_valid = 1'b0; ifb.sh_to_sb = '0; ifb.sh_from_sb = '0;
        #12;
        all_zero("reset");
        rst_n = 1'b1;
        step(1);

        // correct stream
        ifa.sh_from_sb = mask(OUT);
        beat(IN);
        for (int c = 0; c < 5; c++) begin
            chk("busy_run", ifa.busy, 1);
            step(1);
        end
        chk("busy_k5", ifa.busy, 1);
        chk("nchk_k5", ifa.n_checks, 0);
        step(1);
        chk("busy_k6", ifa.busy, 0);
        chk("ok_nchk", ifa.n_checks, 4);
        chk("ok_nerr", ifa.n_errors, 0);
        chk("ok_err", ifa.err, 0);

        // single fault on lane 2
        ifa.sh_from_sb = mask(32'h167d_ed63);
        beat(IN);
        step(5);
        chk("sf_err_k5", ifa.err, 0);
        step(1);
        chk("sf_err", ifa.err, 1);
        chk("sf_nerr", ifa.n_errors, 1);
        chk("sf_nchk", ifa.n_checks, 8);
        chk("sf_lane", ifa.first_lane, 2);
        chk("sf_in", ifa.first_in, 8'h01);
        chk("sf_exp", ifa.first_exp, 8'h7c);
        chk("sf_got", ifa.first_got, 8'h7d);
        do_clear();
        all_zero("clr");

        // multiple faults: beat A lanes 1 and 3, beat B lane 0
        ifa.in_valid = 1'b1;
        ifa.sh_to_sb = mask(IN);
        step(1);
        ifa.sh_to_sb = mask(IN);
        step(1);
        ifa.in_valid = 1'b0;
        step(4);
        ifa.sh_from_sb = mask(32'h007c_ee63);
        step(1);
        chk("mf_nerr_a", ifa.n_errors, 2);
        chk("mf_lane_a", ifa.first_lane, 1);
        chk("mf_in_a", ifa.first_in, 8'h53);
        chk("mf_exp_a", ifa.first_exp, 8'hed);
        chk("mf_got_a", ifa.first_got, 8'hee);
        ifa.sh_from_sb = mask(32'h167c_ed62);
        step(1);
        chk("mf_nerr_b", ifa.n_errors, 3);
        chk("mf_nchk_b", ifa.n_checks, 8);
        chk("mf_lane_b", ifa.first_lane, 1);
        chk("mf_got_b", ifa.first_got, 8'hee);
        chk("mf_err_b", ifa.err, 1);
        do_clear();

        // clear collides with a faulty beat at the tail
        ifa.sh_from_sb = mask(32'h167d_ed63);
        beat(IN);
        step(5);
        ifa.clear = 1'b1;
        step(1);
        ifa.clear = 1'b0;
        all_zero("clrcol");
        ifa.sh_from_sb = mask(32'h177c_ed63);
        beat(IN);
        step(6);
        chk("clean_err", ifa.err, 1);
        chk("clean_lane", ifa.first_lane, 3);
        chk("clean_nerr", ifa.n_errors, 1);
        chk("clean_got", ifa.first_got, 8'h17);

        // asynchronous reset mid-stream
        ifa.sh_from_sb = mask(OUT);
        beat(IN);
        step(2);
        rst_n = 1'b0;
        #2;
        all_zero("arst");
        rst_n = 1'b1;
        step(8);
        chk("arst_nchk", ifa.n_checks, 0);
        chk("arst_busy", ifa.busy, 0);

        // enable low ignores new beats
        ifa.enable = 1'b0;
        ifa.sh_from_sb = mask(32'h0);
        ifa.in_valid = 1'b1;
        ifa.sh_to_sb = mask(IN);
        step(3);
        ifa.in_valid = 1'b0;
        chk("en_busy", ifa.busy, 0);
        step(6);
        chk("en_nchk", ifa.n_checks, 0);
        chk("en_err", ifa.err, 0);

        // enable dropped after acceptance still checks the beat
        ifa.enable = 1'b1;
        ifa.sh_from_sb = mask(OUT);
        beat(IN);
        ifa.enable = 1'b0;
        step(6);
        chk("enmid_nchk", ifa.n_checks, 4);
        chk("enmid_nerr", ifa.n_errors, 0);
        ifa.enable = 1'b1;

        // 4-bit counters saturate at 15
        ifb.sh_from_sb = mask(OUT);
        ifb.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            ifb.sh_to_sb = mask(IN);
            step(1);
        end
        ifb.in_valid = 1'b0;
        step(2);
        chk("sat_1", ifb.n_checks, 4);
        step(1);
        chk("sat_2", ifb.n_checks, 8);
        step(1);
        chk("sat_3", ifb.n_checks, 12);
        step(1);
        chk("sat_4", ifb.n_checks, 15);
        step(1);
        chk("sat_5", ifb.n_checks, 15);
        chk("sat_nerr", ifb.n_errors, 0);
        chk("sat_busy", ifb.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sbox_checker.md
# sbox_checker

Clocked, parametrised testbench monitor for the masked S-box datapath. Recombines up to `LANES` shared byte lanes entering and leaving the S-boxes and aligns inputs to outputs across the S-box pipeline latency. Checks every output byte against the unmasked AES S-box and accumulates error statistics plus a record of the first mismatch. Instantiated in the testbench alongside the core; it has no effect on the design under test.

## Interface

Parameters:

- `d`, 2: number of shares (≥1).
- `LANES`, 4: byte lanes checked in parallel (1..16).
- `LAT`, 6: S-box latency in cycles from input shares to output shares (≥1).
- `CW`, 16: width of the statistics counters.

Ports:

- `clk` in 1: single clock; everything samples on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when low, new `in_valid` beats are ignored; in-flight beats still complete.
- `clear` in 1: synchronous clear of pipeline, counters and capture registers.
- `in_valid` in 1: `sh_to_sb` carries a beat this cycle.
- `sh_to_sb` in 8·d·LANES: shared S-box inputs.
- `sh_from_sb` in 8·d·LANES: shared S-box outputs.
- `busy` out 1: at least one beat is in flight.
- `err` out 1: sticky; a mismatch has been seen since the last reset or clear.
- `n_checks` out CW: lane-checks performed (saturating).
- `n_errors` out CW: lane mismatches (saturating).
- `first_lane` out 4: lane index of the first mismatch.
- `first_in`, `first_exp`, `first_got` out 8 each: for the first mismatch, the recombined input byte, the expected S-box value and the recombined output byte.

## Operation

- **Share layout.** Share j of bit b of lane i is at index 8·d·i + d·b + j. Recombined bit = XOR of its d shares.
- **Input capture.** On a cycle with `in_valid & enable`, the recombined input bytes of all lanes enter a `LAT`-deep shift pipeline together with a valid bit. Otherwise a bubble enters.
- **Check.** When the pipeline tail valid bit is high, `sh_from_sb` is recombined in that same cycle. Each lane is compared with `SBOX(tail_in[lane])`, using the forward AES S-box held in a combinational ROM.
- **Counter updates.**
  - `n_checks` += `LANES`.
  - `n_errors` += popcount of the mismatching lanes.
  - Both saturate at 2^CW−1 and never wrap.
- **States and transitions.**
  - **CLEAN:** no mismatch recorded. On the first check cycle with any mismatch:
    - capture the lowest mismatching lane index and its in/exp/got bytes;
    - set `err`;
    - go to FAULT.
  - **FAULT:** capture registers are frozen; counting continues. Later mismatches, including other lanes in the same cycle, never overwrite the capture.
  - Leave FAULT only via `clear` or reset, which return to CLEAN.
- **`busy`** = OR of all pipeline valid bits.
- **`clear` high:**
  - flushes the pipeline valids;
  - zeroes the counters, `err` and the capture registers;
  - returns to CLEAN.
  - A check that would complete in the same cycle is discarded.
  - An `in_valid` in the same cycle is not captured.
- **Lowering `enable` mid-stream.** Beats already in the pipeline are still checked.

## Timing

- **Reset (`rst_n` low, asynchronous):**
  - every output is 0: `busy`, `err`, counters, `first_*`;
  - pipeline valids are cleared;
  - state is CLEAN.
- **Release.** Takes effect on the first `clk` edge after `rst_n` rises.
- **Latency.** A beat accepted at edge k is checked against `sh_from_sb` sampled at edge k+LAT. Counters, `err` and the capture registers show the result after edge k+LAT.
- **Throughput.** One beat per cycle, back-to-back, with no stall. Lanes are always checked as a group.
- **`busy`.** Rises after edge k and falls after edge k+LAT of the last accepted beat.
- **Reset mid-operation.** Discards all in-flight beats; nothing is checked afterwards.
- **Saturation boundary.** At `n_checks` = 2^CW−LANES+1 the next check yields 2^CW−1.

## Test plan

- **Correct stream.** d=2, LANES=4, LAT=6. Random masks; inputs 0x00, 0x53, 0x01, 0xFF with correct outputs 0x63, 0xED, 0x7C, 0x16. Required: after edge k+6, `n_checks`=4, `n_errors`=0, `err`=0; `busy` high for exactly 6 cycles.
- **Single fault.** Same stimulus with lane 2 output forced to 0x7D. Required:
  - `err` rises exactly after edge k+6;
  - `n_errors`=1, `first_lane`=2, `first_in`=0x01, `first_exp`=0x7C, `first_got`=0x7D.
- **Multiple faults.**
  - Lanes 1 and 3 wrong in beat A, then lane 0 wrong in beat B.
  - Required: `n_errors`=3; capture shows lane 1 of beat A, unchanged after beat B.
- **Clear and reset collisions.**
  - `clear` asserted in the same cycle a faulty beat reaches the tail. Required: counters 0, `err` 0, state CLEAN.
  - Separately, `rst_n` pulsed low between edges mid-stream. Required: all outputs 0 immediately; `busy` 0; no later checks.
- **Enable and saturation.**
  - `enable` low during 3 valid beats: `n_checks` unchanged.
  - CW=4, LANES=4, 5 correct beats: `n_checks` saturates at 15 and does not wrap to 4.
